// File: rtl/act_fetch_resp_pkg.sv
// Shared parameters and types for the activation fetch responder.
// Also provides the log2 helper that sizes the row-length config field.
package act_fetch_resp_pkg;

  localparam int ACT_WIDTH_D  = 8;
  localparam int ADDR_WIDTH_D = 10;
  localparam int LENROW_D     = 16;
  localparam int PND_WIDTH_D  = 2;

  typedef struct packed {
    logic frt;
    logic lst;
  } row_tag_t;

  function automatic int c_log_2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/act_credit_cnt.sv
// Saturating up/down counter with a one-cycle overflow flag.
// A load takes priority over counting and never flags overflow.
module act_credit_cnt #(
  parameter int          W   = 2,
  parameter int unsigned MAX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic [W-1:0] cnt_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MaxV = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == MaxV) ovf_o = 1'b1;
      else               cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/act_fetch_resp.sv
// Activation fetch responder: serves controller fetch pulses from the
// circular activation SRAM, gated by loader fill credit.
module act_fetch_resp
  import act_fetch_resp_pkg::*;
#(
  parameter int ACT_WIDTH  = ACT_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int LENROW     = LENROW_D,
  parameter int PND_WIDTH  = PND_WIDTH_D,
  parameter int LR_W       = c_log_2(LENROW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  TOP_Sta,
  input  logic [LR_W-1:0]       CFG_LenRow,
  input  logic                  CTRLACT_PlsFetch,
  output logic                  CTRLACT_GetAct,
  output logic [ACT_WIDTH-1:0]  ACT_Dat,
  output logic                  ACT_FrtRow,
  output logic                  ACT_LstRow,
  input  logic                  ACTBUF_WrPls,
  output logic                  SRAM_RdEn,
  output logic [ADDR_WIDTH-1:0] SRAM_RdAddr,
  input  logic [ACT_WIDTH-1:0]  SRAM_RdDat,
  output logic                  ACT_Err
);

  logic [PND_WIDTH-1:0]  pnd;
  logic [ADDR_WIDTH:0]   avl;
  logic                  pnd_ovf, avl_ovf;
  logic                  issue, get;

  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [LR_W-1:0]       pos_q, pos_d;
  logic                  rdvld_q, rdvld_d;
  row_tag_t              tag_q, tag_d;
  logic [ACT_WIDTH-1:0]  dat_q, dat_d;
  logic                  err_q, err_d;

  // A start cycle never issues, so no credit is spent on a read
  // that would be thrown away.
  assign issue = (pnd != '0) && (avl != '0) && !TOP_Sta;
  assign get   = rdvld_q && !TOP_Sta;

  act_credit_cnt #(
    .W   (PND_WIDTH),
    .MAX ((1 << PND_WIDTH) - 1)
  ) u_pnd (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (CTRLACT_PlsFetch),
    .dec_i    (issue),
    .ld_i     (TOP_Sta),
    .ld_val_i (PND_WIDTH'(CTRLACT_PlsFetch)),
    .cnt_o    (pnd),
    .ovf_o    (pnd_ovf)
  );

  act_credit_cnt #(
    .W   (ADDR_WIDTH + 1),
    .MAX (1 << ADDR_WIDTH)
  ) u_avl (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (ACTBUF_WrPls),
    .dec_i    (issue),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .cnt_o    (avl),
    .ovf_o    (avl_ovf)
  );

  always_comb begin
    rd_addr_d = rd_addr_q;
    pos_d     = pos_q;
    rdvld_d   = issue;
    tag_d     = tag_q;
    dat_d     = dat_q;
    err_d     = err_q | pnd_ovf | avl_ovf;
    if (TOP_Sta) begin
      rd_addr_d = '0;
      pos_d     = '0;
      rdvld_d   = 1'b0;
    end else begin
      if (get) dat_d = SRAM_RdDat;
      if (issue) begin
        rd_addr_d = rd_addr_q + 1'b1;
        tag_d.frt = (pos_q == '0);
        tag_d.lst = (pos_q == CFG_LenRow);
        pos_d     = (pos_q == CFG_LenRow) ? '0 : pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      pos_q     <= '0;
      rdvld_q   <= 1'b0;
      tag_q     <= '0;
      dat_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      pos_q     <= pos_d;
      rdvld_q   <= rdvld_d;
      tag_q     <= tag_d;
      dat_q     <= dat_d;
      err_q     <= err_d;
    end
  end

  // Read data is live in the return cycle and held afterwards.
  assign CTRLACT_GetAct = get;
  assign ACT_Dat        = get ? SRAM_RdDat : dat_q;
  assign ACT_FrtRow     = get & tag_q.frt;
  assign ACT_LstRow     = get & tag_q.lst;
  assign SRAM_RdEn      = issue;
  assign SRAM_RdAddr    = rd_addr_q;
  assign ACT_Err        = err_q;

endmodule

// File: tb/tb_act_fetch_resp.sv
// Scoreboard bench for act_fetch_resp with an 8-entry SRAM model.
// Expected reads and returns are queued by stimulus, checked by a monitor.
module tb_act_fetch_resp;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sta = 1'b0;
  logic [LW-1:0] lenrow = 4'd3;
  logic          fetch = 1'b0;
  logic          wr = 1'b0;
  logic          get_act;
  logic [DW-1:0] act_dat;
  logic          frt, lst;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_dat = '0;
  logic          err;

  logic [DW-1:0] mem [8];

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          frt;
    logic          lst;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_get = 0;
  int            base;

  always #5 clk = ~clk;

  act_fetch_resp #(
    .ACT_WIDTH  (DW),
    .ADDR_WIDTH (AW),
    .LENROW     (16),
    .PND_WIDTH  (2)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .TOP_Sta          (sta),
    .CFG_LenRow       (lenrow),
    .CTRLACT_PlsFetch (fetch),
    .CTRLACT_GetAct   (get_act),
    .ACT_Dat          (act_dat),
    .ACT_FrtRow       (frt),
    .ACT_LstRow       (lst),
    .ACTBUF_WrPls     (wr),
    .SRAM_RdEn        (rd_en),
    .SRAM_RdAddr      (rd_addr),
    .SRAM_RdDat       (rd_dat),
    .ACT_Err          (err)
  );

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
  end

  always @(posedge clk) begin
    if (rd_en) rd_dat <= mem[rd_addr];
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_get(int a, int d, bit f, bit l);
    exp_t e;
    addr_q.push_back(AW'(a));
    e.dat = DW'(d);
    e.frt = f;
    e.lst = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every read and every return must match the queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: got addr %0h want no read", rd_addr);
        end else begin
          chk("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
        end
      end
      if (get_act) begin
        n_get++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL get_unexpected: got dat %0h want no GetAct", act_dat);
        end else begin
          chk("get_dat_frt_lst", 32'({act_dat, frt, lst}),
              32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_getact", 32'(get_act), 0);
    chk("rst_rden", 32'(rd_en), 0);
    chk("rst_dat", 32'(act_dat), 0);
    chk("rst_tags", 32'({frt, lst}), 0);
    chk("rst_err", 32'(err), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic fetch: start+fetch together, read next cycle, data after.
    wr = 1'b1;
    repeat (4) tick();
    wr = 1'b0;
    push_get(0, 8'hA0, 1, 0);
    sta = 1'b1;
    fetch = 1'b1;
    @(negedge clk);
    chk("t1_no_rden_same_cycle", 32'(rd_en), 0);
    tick();
    sta = 1'b0;
    fetch = 1'b0;
    @(negedge clk);
    chk("t1_rden_t1", 32'(rd_en), 1);
    tick();
    @(negedge clk);
    chk("t1_getact_t2", 32'(get_act), 1);
    chk("t1_dat", 32'(act_dat), 32'hA0);
    tick();
    tick();
    @(negedge clk);
    chk("t1_dat_held", 32'(act_dat), 32'hA0);

    // Row tagging: 8 back-to-back words, rows of 4.
    lenrow = 4'd3;
    tick();
    sta = 1'b1;
    tick();
    sta = 1'b0;
    wr = 1'b1;
    repeat (5) tick();
    wr = 1'b0;
    for (int i = 0; i < 8; i++)
      push_get(i, 8'hA0 + i, (i == 0) || (i == 4), (i == 3) || (i == 7));
    base = n_get;
    fetch = 1'b1;
    repeat (8) tick();
    fetch = 1'b0;
    repeat (4) tick();
    chk("t2_getact_count", 32'(n_get - base), 8);

    // Address wrap: 10 fetches with matching credits, rows of 5.
    lenrow = 4'd4;
    sta = 1'b1;
    tick();
    sta = 1'b0;
    for (int i = 0; i < 10; i++)
      push_get(i % 8, 8'hA0 + (i % 8), (i % 5) == 0, (i % 5) == 4);
    base = n_get;
    wr = 1'b1;
    fetch = 1'b1;
    repeat (10) tick();
    wr = 1'b0;
    fetch = 1'b0;
    repeat (4) tick();
    chk("t4_getact_count", 32'(n_get - base), 10);

    // Credit starvation: two requests wait until one credit arrives.
    fetch = 1'b1;
    repeat (2) tick();
    fetch = 1'b0;
    repeat (5) tick();
    chk("t3_pnd_waiting", 32'(u_dut.u_pnd.cnt_q), 2);
    push_get(2, 8'hA2, 1, 0);
    wr = 1'b1;
    @(negedge clk);
    chk("t3_no_rden_with_credit", 32'(rd_en), 0);
    tick();
    wr = 1'b0;
    @(negedge clk);
    chk("t3_rden", 32'(rd_en), 1);
    tick();
    @(negedge clk);
    chk("t3_getact", 32'(get_act), 1);
    repeat (3) tick();
    chk("t3_pnd_left", 32'(u_dut.u_pnd.cnt_q), 1);
    sta = 1'b1;
    tick();
    sta = 1'b0;

    // Restart mid-flight: the read in flight returns nothing.
    push_get(0, 8'hA0, 1, 0);
    wr = 1'b1;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();
    wr = 1'b0;
    repeat (3) tick();
    addr_q.push_back(AW'(1));
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();
    sta = 1'b1;
    @(negedge clk);
    chk("t5_getact_suppressed", 32'(get_act), 0);
    tick();
    sta = 1'b0;
    repeat (2) tick();
    push_get(0, 8'hA0, 1, 0);
    wr = 1'b1;
    fetch = 1'b1;
    tick();
    wr = 1'b0;
    fetch = 1'b0;
    repeat (4) tick();

    // Pending overflow: error is sticky across start, cleared by reset.
    chk("t6_err_pre", 32'(err), 0);
    fetch = 1'b1;
    repeat (4) tick();
    fetch = 1'b0;
    @(negedge clk);
    chk("t6_pnd_sat", 32'(u_dut.u_pnd.cnt_q), 3);
    chk("t6_err_set", 32'(err), 1);
    tick();
    sta = 1'b1;
    tick();
    sta = 1'b0;
    @(negedge clk);
    chk("t6_err_sticky", 32'(err), 1);
    rst_n = 1'b0;
    #2;
    chk("t6_err_rst", 32'(err), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Credit overflow: a ninth write into an 8-deep buffer.
    wr = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("t7_avl_full", 32'(u_dut.u_avl.cnt_q), 8);
    chk("t7_err_pre", 32'(err), 0);
    tick();
    wr = 1'b0;
    @(negedge clk);
    chk("t7_avl_sat", 32'(u_dut.u_avl.cnt_q), 8);
    chk("t7_err_set", 32'(err), 1);
    tick();

    chk("end_addr_q_empty", 32'(addr_q.size()), 0);
    chk("end_exp_q_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
